iob_eth_ctrl: RTL
=================

Name: iob_eth_ctrl

Overview:
- Frame-level sequencer that masters the Ethernet core's CPU register bus (valid/ready/wstrb/addr/data) on behalf of two requesters: a TX requester and an RX requester.
- TX path: polls STATUS for tx_ready, programs TX_NBYTES, then writes SEND.
- RX path: polls STATUS for rx_data_rcvd, reads RCV_SIZE, then writes RCVACK.
- Round-robin arbitration when both requesters are pending; a poll timeout guards against a dead PHY.

Parameters:
ETH_ADDR_W, 12, register address width
A_STATUS, 0, STATUS register address (bit0 tx_ready, bit1 rx_data_rcvd)
A_SEND, 1, SEND register address
A_RCVACK, 2, RCVACK register address
A_TX_NBYTES, 4, TX_NBYTES register address
A_RCV_SIZE, 7, RCV_SIZE register address (rdata[10:0] valid)
POLL_GAP, 4, idle cycles between consecutive STATUS reads (>=1)
POLL_MAX, 1024, STATUS reads before timeout (>=1)

Ports:
clk  in  1  clock
rst_int  in  1  asynchronous active-high reset
tx_req_valid  in  1  TX frame request
tx_req_ready  out  1  TX request accepted this cycle
tx_nbytes  in  11  frame payload byte count, sampled on TX accept
tx_done  out  1  one-cycle pulse, TX sequence finished
rx_req_valid  in  1  RX request (wait for frame)
rx_req_ready  out  1  RX request accepted this cycle
rx_done  out  1  one-cycle pulse, RX sequence finished
rx_size  out  11  RCV_SIZE value, valid with rx_done, held until next rx_done
err  out  1  one-cycle pulse alongside tx_done/rx_done on poll timeout
busy  out  1  high in every state except IDLE
eth_valid  out  1  register-bus request
eth_addr  out  ETH_ADDR_W  register-bus address
eth_wstrb  out  4  4'hF for writes, 4'h0 for reads
eth_wdata  out  32  write data
eth_rdata  in  32  read data (combinational from eth_addr)
eth_ready  in  1  bus completion (core returns ready one cycle after valid)

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours TX; poll counter 0; rx_size 0.
- Bus transaction rules:
  - eth_valid, eth_addr, eth_wstrb and eth_wdata are registered and held stable until the cycle in which eth_ready=1.
  - eth_valid deasserts the following cycle, so there are no back-to-back transactions.
  - Read data is captured from eth_rdata in the eth_ready=1 cycle.
  - Nominal transaction latency is 2 cycles (valid high, ready returned).
- Arbitration (IDLE only):
  - Only TX valid: grant TX. Only RX valid: grant RX.
  - Both valid: grant the side the pointer favours, then point the pointer at the other side.
  - The grant pulses the matching *_req_ready for 1 cycle in IDLE. tx_nbytes is latched in the same cycle.
- States: IDLE -> POLL_RD -> POLL_GAP -> (TX: WR_NBYTES -> WR_SEND) | (RX: RD_SIZE -> WR_ACK) -> DONE -> IDLE.
- POLL_RD: read A_STATUS and check the needed bit (TX bit0, RX bit1).
  - Bit set: go to WR_NBYTES / RD_SIZE.
  - Bit clear: increment the poll counter and go to POLL_GAP.
  - Counter reaches POLL_MAX: go to DONE with the timeout flag set.
- POLL_GAP: wait POLL_GAP cycles, then return to POLL_RD.
- WR_NBYTES: write {21'b0, tx_nbytes_latched} to A_TX_NBYTES.
- WR_SEND: write 32'h1 to A_SEND.
- RD_SIZE: read A_RCV_SIZE and latch rdata[10:0] into an internal register.
- WR_ACK: write 32'h1 to A_RCVACK.
- DONE (1 cycle):
  - Pulse tx_done or rx_done for the granted side; pulse err if the timeout flag is set.
  - rx_size updates on non-timeout RX only; on timeout the previous value is kept.
  - Clear the poll counter and timeout flag, return to IDLE.
  - A new request can be accepted in the cycle after DONE, so the minimum gap between done and next accept is 1 cycle.
- Requests are not queued internally. A requester keeps *_req_valid high until it sees *_req_ready. Deasserting valid before acceptance is legal; the request is simply dropped.
- Requests arriving while busy wait and are not acknowledged.
- Poll counter width is clog2(POLL_MAX+1). It saturates and never wraps.
- A rst_int assertion mid-transaction:
  - immediately clears eth_valid and all pulses and returns to IDLE;
  - leaves no partial write pending, because the core shares the same reset.
- eth_ready=1 while eth_valid=0 is ignored.

Test Plan:
- TX, STATUS=32'h1 at first poll, tx_nbytes=11'd60:
  - exactly 3 bus transactions in order: read addr 0, write addr 4 data 32'd60, write addr 1 data 32'h1.
  - then tx_done pulse, err=0.
- RX, STATUS bit1 clear for 3 polls then set, RCV_SIZE returns 32'h0000_0040:
  - 4 STATUS reads spaced >= POLL_GAP+2 cycles apart, then read addr 7, then write addr 2 data 32'h1.
  - rx_done pulse with rx_size=11'd64.
- tx_req_valid and rx_req_valid high together from reset, repeatedly:
  - grants alternate TX, RX, TX, RX.
  - busy stays low for exactly 1 cycle between sequences.
- POLL_MAX=8, STATUS stuck 0 on a TX request:
  - exactly 8 STATUS reads, no writes.
  - tx_done and err pulse together; rx_size unchanged.
- rst_int asserted while eth_valid is high in WR_NBYTES:
  - eth_valid=0 asynchronously, busy=0.
  - next tx request restarts from a STATUS read.
- eth_ready withheld for 5 cycles during WR_SEND:
  - eth_addr, eth_wdata and eth_valid stay stable throughout.
  - tx_done pulses 2 cycles after eth_ready.

Source files
------------

// File: rtl/iob_eth_ctrl_if.sv
// Register-bus bundle between the frame sequencer (master) and the Ethernet core (slave).
interface iob_eth_ctrl_if #(
  parameter int ETH_ADDR_W = 12
);
  logic                  eth_valid;
  logic [ETH_ADDR_W-1:0] eth_addr;
  logic [3:0]            eth_wstrb;
  logic [31:0]           eth_wdata;
  logic [31:0]           eth_rdata;
  logic                  eth_ready;

  modport master (
    output eth_valid, eth_addr, eth_wstrb, eth_wdata,
    input  eth_rdata, eth_ready
  );

  modport slave (
    input  eth_valid, eth_addr, eth_wstrb, eth_wdata,
    output eth_rdata, eth_ready
  );
endinterface

// File: rtl/iob_eth_ctrl.sv
// Frame-level sequencer driving the Ethernet core register bus for a TX and an RX requester,
// with round-robin arbitration and a STATUS poll timeout.
module iob_eth_ctrl #(
  parameter int ETH_ADDR_W  = 12,
  parameter int A_STATUS    = 0,
  parameter int A_SEND      = 1,
  parameter int A_RCVACK    = 2,
  parameter int A_TX_NBYTES = 4,
  parameter int A_RCV_SIZE  = 7,
  parameter int POLL_GAP    = 4,
  parameter int POLL_MAX    = 1024
) (
  input  logic        clk,
  input  logic        rst_int,
  input  logic        tx_req_valid,
  output logic        tx_req_ready,
  input  logic [10:0] tx_nbytes,
  output logic        tx_done,
  input  logic        rx_req_valid,
  output logic        rx_req_ready,
  output logic        rx_done,
  output logic [10:0] rx_size,
  output logic        err,
  output logic        busy,
  iob_eth_ctrl_if.master eth
);

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_MAX - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [ETH_ADDR_W-1:0] ADDR_STATUS    = ETH_ADDR_W'(A_STATUS);
  localparam logic [ETH_ADDR_W-1:0] ADDR_SEND      = ETH_ADDR_W'(A_SEND);
  localparam logic [ETH_ADDR_W-1:0] ADDR_RCVACK    = ETH_ADDR_W'(A_RCVACK);
  localparam logic [ETH_ADDR_W-1:0] ADDR_TX_NBYTES = ETH_ADDR_W'(A_TX_NBYTES);
  localparam logic [ETH_ADDR_W-1:0] ADDR_RCV_SIZE  = ETH_ADDR_W'(A_RCV_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL_RD, S_POLL_GAP, S_WR_NBYTES, S_WR_SEND, S_RD_SIZE, S_WR_ACK, S_DONE
  } state_t;

  state_t           state;
  logic             rr_tx;
  logic             side_tx;
  logic             timeout;
  logic [10:0]      nbytes_lat;
  logic [10:0]      size_lat;
  logic [CNT_W-1:0] poll_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant_tx;
  logic             grant_rx;
  logic             status_hit;
  logic             unused_rdata;

  // With both requesters pending the pointer decides; a lone requester always wins.
  always_comb begin
    grant_tx   = tx_req_valid && (!rx_req_valid || rr_tx);
    grant_rx   = rx_req_valid && !grant_tx;
    status_hit = side_tx ? eth.eth_rdata[0] : eth.eth_rdata[1];
  end

  assign tx_req_ready = (state == S_IDLE) && grant_tx;
  assign rx_req_ready = (state == S_IDLE) && grant_rx;
  assign unused_rdata = ^eth.eth_rdata[31:11];

  // Each bus state launches its transaction from a cycle with eth_valid low, which keeps
  // one idle bus cycle between consecutive transactions.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state         <= S_IDLE;
      rr_tx         <= 1'b1;
      side_tx       <= 1'b0;
      timeout       <= 1'b0;
      nbytes_lat    <= '0;
      size_lat      <= '0;
      poll_cnt      <= '0;
      gap_cnt       <= '0;
      tx_done       <= 1'b0;
      rx_done       <= 1'b0;
      rx_size       <= '0;
      err           <= 1'b0;
      busy          <= 1'b0;
      eth.eth_valid <= 1'b0;
      eth.eth_addr  <= '0;
      eth.eth_wstrb <= 4'h0;
      eth.eth_wdata <= '0;
    end else begin
      tx_done <= 1'b0;
      rx_done <= 1'b0;
      err     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_tx || grant_rx) begin
            side_tx <= grant_tx;
            if (grant_tx) nbytes_lat <= tx_nbytes;
            if (tx_req_valid && rx_req_valid) rr_tx <= ~rr_tx;
            busy  <= 1'b1;
            state <= S_POLL_RD;
          end
        end
        S_POLL_RD: begin
          if (!eth.eth_valid) begin
            eth.eth_valid <= 1'b1;
            eth.eth_addr  <= ADDR_STATUS;
            eth.eth_wstrb <= 4'h0;
            eth.eth_wdata <= '0;
          end else if (eth.eth_ready) begin
            eth.eth_valid <= 1'b0;
            if (status_hit) begin
              state <= side_tx ? S_WR_NBYTES : S_RD_SIZE;
            end else begin
              if (poll_cnt != CNT_MAX) poll_cnt <= poll_cnt + 1'b1;
              gap_cnt <= '0;
              if (poll_cnt >= CNT_LAST) begin
                timeout <= 1'b1;
                state   <= S_DONE;
              end else begin
                state <= S_POLL_GAP;
              end
            end
          end
        end
        S_POLL_GAP: begin
          if (gap_cnt == GAP_LAST) state <= S_POLL_RD;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        S_WR_NBYTES: begin
          if (!eth.eth_valid) begin
            eth.eth_valid <= 1'b1;
            eth.eth_addr  <= ADDR_TX_NBYTES;
            eth.eth_wstrb <= 4'hF;
            eth.eth_wdata <= {21'b0, nbytes_lat};
          end else if (eth.eth_ready) begin
            eth.eth_valid <= 1'b0;
            state         <= S_WR_SEND;
          end
        end
        S_WR_SEND: begin
          if (!eth.eth_valid) begin
            eth.eth_valid <= 1'b1;
            eth.eth_addr  <= ADDR_SEND;
            eth.eth_wstrb <= 4'hF;
            eth.eth_wdata <= 32'h1;
          end else if (eth.eth_ready) begin
            eth.eth_valid <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_RD_SIZE: begin
          if (!eth.eth_valid) begin
            eth.eth_valid <= 1'b1;
            eth.eth_addr  <= ADDR_RCV_SIZE;
            eth.eth_wstrb <= 4'h0;
            eth.eth_wdata <= '0;
          end else if (eth.eth_ready) begin
            eth.eth_valid <= 1'b0;
            size_lat      <= eth.eth_rdata[10:0];
            state         <= S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (!eth.eth_valid) begin
            eth.eth_valid <= 1'b1;
            eth.eth_addr  <= ADDR_RCVACK;
            eth.eth_wstrb <= 4'hF;
            eth.eth_wdata <= 32'h1;
          end else if (eth.eth_ready) begin
            eth.eth_valid <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          tx_done <= side_tx;
          rx_done <= !side_tx;
          err     <= timeout;
          if (!side_tx && !timeout) rx_size <= size_lat;
          poll_cnt <= '0;
          timeout  <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
